z_run_monitor: RTL
==================

Name: z_run_monitor

Overview:
- Sits directly downstream of the x/z detector FSM and consumes its 1-bit z output every clock.
- Measures each run of consecutive z-high cycles and queues the run length with a saturation flag in a small FIFO.
- Results drain to the control side over a valid/ready interface.
- Lost runs are flagged by a sticky overflow bit.

Parameters:
- CNT_W, 8, width of the run-length counter and out_len; maximum recordable length is 2^CNT_W-1.
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- z  input  1  detector output stream, sampled every rising edge of clk.
- run_active  output  1  registered copy of the previous sample of z (z_q).
- out_valid  output  1  FIFO non-empty; the head entry is presented.
- out_ready  input  1  consumer accepts the head entry when out_valid is also high.
- out_len  output  CNT_W  head entry run length, in cycles.
- out_sat  output  1  head entry length saturated; true run length is at least 2^CNT_W-1.
- overflow  output  1  sticky: at least one completed run was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high, on a clk edge with reset=1):
  - z_q=0, cnt=0, sat=0, FIFO emptied (rd_ptr=wr_ptr=0, count=0), overflow=0.
  - Therefore run_active=0, out_valid=0, out_len=0, out_sat=0.
  - Reset has priority over every other event: an in-progress run is discarded, queued entries are discarded, and no pop is counted.
- Run counting, evaluated at each non-reset edge:
  - z=1, z_q=0 (run start): cnt<=1, sat<=0.
  - z=1, z_q=1: if cnt==2^CNT_W-1 then hold cnt and set sat<=1; else cnt<=cnt+1.
  - z=0, z_q=1 (run end): push {sat,cnt} to the FIFO, then cnt<=0, sat<=0.
  - z=0, z_q=0: idle, no change.
  - z_q<=z at every edge.
- Run length = number of consecutive edges at which z was sampled 1. A single-cycle pulse gives length 1.
- Latency: a run ending at edge N (first z=0 sample) is visible as out_valid=1 in the cycle after edge N, provided the FIFO was empty. out_len/out_sat are taken combinationally from the head entry register.
- A run still active when reset asserts is never pushed.
- FIFO:
  - Pop when out_valid && out_ready at an edge.
  - Push and pop at the same edge: both take effect; count is unchanged. This holds even when the FIFO is full, because the pop frees the slot and the push is accepted.
  - Push when full with no pop: entry dropped, FIFO contents unchanged, overflow<=1. overflow is cleared only by reset.
  - Pointers wrap modulo DEPTH.
  - out_ready while empty has no effect.
- Output is stable while out_valid=1 and out_ready=0: out_len/out_sat must not change, even if pushes occur behind the head.
- Outputs when empty: out_len/out_sat are don't-care; the bench must not check them.
- Timing: all outputs registered or derived from registers only. No combinational path from z or out_ready to any output.

Test Plan:
- Single pulse: after reset, z=1 for 1 cycle then 0, out_ready=1 -> out_valid pulses one cycle with out_len=1, out_sat=0; run_active high exactly one cycle.
- Back-to-back runs: z pattern 1,1,1,0,1,1,0 with out_ready=0 -> FIFO holds two entries, read in order out_len=3 then out_len=2; overflow=0.
- Saturation: CNT_W=8, z=1 for 300 cycles then 0 -> one entry with out_len=255, out_sat=1; the next run of 5 cycles gives out_len=5, out_sat=0.
- Overflow and full-boundary push+pop:
  - out_ready=0, five runs of lengths 1..5 with DEPTH=4 -> entries 1,2,3,4 kept; run 5 dropped; overflow=1 and stays 1 after draining.
  - Repeat with out_ready=1 asserted on the same edge as the fifth push -> nothing dropped, overflow=0.
- Reset mid-operation: two entries queued and a run of length 6 in progress, reset asserted for one cycle -> next cycle out_valid=0, overflow=0, run_active=0. A fresh run of 2 after reset reports out_len=2 (no residue from the aborted run).
- Backpressure stability: entry out_len=7 held with out_ready=0 for 10 cycles while two more runs complete -> out_len stays 7 throughout; after the pop, the next entries appear in arrival order.

Source files
------------

// File: rtl/z_run_monitor.sv
// Run-length monitor for the x/z detector's z stream: measures each run of
// consecutive z-high samples and queues {saturated, length} for the control side.
module z_run_monitor #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             z,
   output logic             run_active,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_len,
   output logic             out_sat,
   output logic             overflow
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   // Entry layout: MSB is the saturation flag, low CNT_W bits the length.
   typedef logic [CNT_W:0] entry_t;

   logic             z_q, z_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;
   entry_t           mem_q [DEPTH];
   entry_t           mem_d [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic push, pop, full, wr_en;

   always_comb begin
      z_d   = z;
      cnt_d = cnt_q;
      sat_d = sat_q;
      push  = 1'b0;
      if (z && !z_q) begin
         cnt_d = CNT_W'(1);
         sat_d = 1'b0;
      end else if (z && z_q) begin
         // Length pins at the maximum; the flag records that it was clipped.
         if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else if (!z && z_q) begin
         push  = 1'b1;
         cnt_d = '0;
         sat_d = 1'b0;
      end
   end

   always_comb begin
      pop   = (count_q != '0) && out_ready;
      full  = (count_q == FULL_CNT);
      // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
      wr_en = push && (!full || pop);

      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = {sat_q, cnt_q};
      end

      wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      count_d = count_q;
      case ({wr_en, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase

      overflow_d = overflow_q | (push && !wr_en);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         z_q        <= 1'b0;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         mem_q      <= '{default: '0};
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         z_q        <= z_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         mem_q      <= mem_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign run_active = z_q;
   assign out_valid  = (count_q != '0);
   assign out_len    = mem_q[rd_ptr_q][CNT_W-1:0];
   assign out_sat    = mem_q[rd_ptr_q][CNT_W];
   assign overflow   = overflow_q;

endmodule
